// File: rtl/speed_pkg.sv
// Types and constants shared between the playback speed controller and its
// consumer, the sample-rate generator.
package speed_pkg;

    typedef logic [31:0] period_t;

    typedef enum logic {
        SRG_IDLE = 1'b0,
        SRG_RUN  = 1'b1
    } srg_state_t;

    localparam period_t DEFAULT_SPEED = period_t'(3472);

    // Unsigned compare: every 32-bit word, including all-ones, is a legal period.
    function automatic period_t clamp_period(input period_t div, input period_t min_div);
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/period_counter.sv
// Loadable down-counter for one sample period: loads clamp(div_count)-1,
// flags terminal count at zero and reloads from the live div_count there.
module period_counter
    import speed_pkg::*;
#(
    parameter int unsigned MIN_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        run,
    input  logic [31:0] div_count,
    output logic [31:0] clamped,
    output logic        tc
);

    period_t count_q;
    period_t count_d;

    always_comb begin
        clamped = clamp_period(div_count, period_t'(MIN_DIV));
        tc      = (count_q == '0);
    end

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = clamped - 1'b1;
        end else if (run) begin
            count_d = tc ? (clamped - 1'b1) : (count_q - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sample_rate_gen.sv
// Turns the div_count period word into a req/ack sample-request strobe and
// counts missed acknowledgements. Optional debug output: SRG_TOGGLE_OUT_EN.
module sample_rate_gen
    import speed_pkg::*;
#(
    parameter int unsigned MIN_DIV = 2,
    parameter int unsigned MISS_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       div_count,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_ack,
    output logic              sample_req,
    output logic              running,
    output logic [31:0]       active_period,
`ifdef SRG_TOGGLE_OUT_EN
    output logic              tick_toggle,
`endif
    output logic              overrun,
    output logic [MISS_W-1:0] missed
);

    srg_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              running_q, running_d;
    period_t           active_period_q, active_period_d;
    logic              overrun_q, overrun_d;
    logic [MISS_W-1:0] missed_q, missed_d;

    logic              load;
    logic              run_en;
    logic              tick;
    period_t           clamped;
    logic              tc;

    period_counter #(
        .MIN_DIV (MIN_DIV)
    ) u_period_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .run       (run_en),
        .div_count (div_count),
        .clamped   (clamped),
        .tc        (tc)
    );

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        active_period_d = active_period_q;
        overrun_d       = overrun_q;
        missed_d        = missed_q;
        load            = 1'b0;
        run_en          = 1'b0;
        tick            = 1'b0;

        case (state_q)
            SRG_IDLE: begin
                req_d = 1'b0;
                if (!stop && start) begin
                    state_d         = SRG_RUN;
                    load            = 1'b1;
                    active_period_d = clamped;
                end
            end
            SRG_RUN: begin
                // stop beats a tick due on the same edge
                if (stop) begin
                    state_d = SRG_IDLE;
                    req_d   = 1'b0;
                end else begin
                    run_en = 1'b1;
                    if (tc) begin
                        tick            = 1'b1;
                        active_period_d = clamped;
                        req_d           = 1'b1;
                        if (req_q && !sample_ack) begin
                            overrun_d = 1'b1;
                            if (missed_q != '1) begin
                                missed_d = missed_q + 1'b1;
                            end
                        end
                    end else if (sample_ack) begin
                        req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = SRG_IDLE;
                req_d   = 1'b0;
            end
        endcase

        running_d = (state_d == SRG_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= SRG_IDLE;
            req_q           <= 1'b0;
            running_q       <= 1'b0;
            active_period_q <= period_t'(MIN_DIV);
            overrun_q       <= 1'b0;
            missed_q        <= '0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            running_q       <= running_d;
            active_period_q <= active_period_d;
            overrun_q       <= overrun_d;
            missed_q        <= missed_d;
        end
    end

`ifdef SRG_TOGGLE_OUT_EN
    logic toggle_q, toggle_d;

    always_comb begin
        toggle_d = toggle_q ^ tick;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign tick_toggle = toggle_q;
`endif

    assign sample_req    = req_q;
    assign running       = running_q;
    assign active_period = active_period_q;
    assign overrun       = overrun_q;
    assign missed        = missed_q;

endmodule

// File: doc/sample_rate_gen.md
# sample_rate_gen

Consumer side of the playback speed interface: takes the 32-bit `div_count` period word produced by the speed controller and turns it into a steady sample-request strobe for the audio sample fetcher. Each period of `div_count` system clocks yields one request on a req/ack handshake. Period changes take effect only at period boundaries, so playback speed changes never produce runt or stretched intervals. Missed acknowledgements are counted so that too-fast playback settings show up in verification.

## Interface
- `MIN_DIV`, default 2: smallest period honoured; a smaller `div_count` (including 0) is clamped to this value.
- `MISS_W`, default 8: width of the missed-sample counter.
- `clk` in 1: system clock; everything is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `div_count` in 32: requested period in `clk` cycles, unsigned; may change on any cycle.
- `start` in 1: level or pulse; begins generation from IDLE.
- `stop` in 1: level or pulse; returns to IDLE from any state.
- `sample_ack` in 1: fetcher has consumed the current request.
- `sample_req` out 1: sample request; held until acknowledged.
- `running` out 1: high in RUN.
- `active_period` out 32: clamped period currently being timed.
- `overrun` out 1: sticky; set when a tick occurs while a request is still pending.
- `missed` out MISS_W: count of overrun ticks, saturating.

## Operation
- FSM states:
  - IDLE: counter held and `sample_req` cleared; `overrun` and `missed` are *not* cleared.
  - RUN: counter is active.
- IDLE→RUN on `start`; RUN→IDLE on `stop`. If `start` and `stop` are sampled together, `stop` wins.
- Entering RUN:
  - `active_period` ← max(`div_count`, `MIN_DIV`).
  - Counter ← that value − 1.
- In RUN, counter decrements by 1 per cycle. When the counter is 0 (the terminal edge):
  - Counter reloads with max(`div_count`, `MIN_DIV`) − 1, using `div_count` sampled on that same edge.
  - `active_period` updates to the same clamped value.
  - A tick is issued.
- Tick handling:
  - Request clear: `sample_req` = 0 → set to 1.
  - Request pending without `sample_ack` → `sample_req` stays 1, `overrun` ← 1, `missed` increments (saturates at all-ones).
  - Tick and `sample_ack` on the same edge → `sample_req` stays 1 (new request, no overrun).
- `sample_ack` while `sample_req` = 1 and no tick: clears `sample_req` on that edge.
- `sample_ack` while `sample_req` = 0: ignored.
- The clamp compare is unsigned 32-bit. There is no wrap: 0xFFFFFFFF is a legal period.
- `overrun` and `missed` clear only on reset.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - `active_period` = `MIN_DIV`.
  - `sample_req` = 0, `running` = 0, `overrun` = 0, `missed` = 0.
- Tick cadence:
  - `start` sampled at edge 0 → `running` = 1 after edge 0.
  - First `sample_req` rises after edge P (P = clamped period).
  - Subsequent ticks follow every P cycles.
- A new `div_count` becomes effective on the terminal edge of the current period. The period in progress is never shortened or stretched.
- `stop` at edge k:
  - `running` = 0 and `sample_req` = 0 after edge k.
  - A tick due on edge k is suppressed.
- Asserting `reset_n` mid-period aborts immediately to the reset values. Generation does not resume until a fresh `start`.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- `SRG_TOGGLE_OUT_EN`:
  - Defined: adds output `tick_toggle` (1 bit, reset 0), which inverts on every tick. This gives a square wave at half the sample rate for LED/scope debug.
  - Undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package `speed_pkg`: holds the FSM state enum `srg_state_t` {SRG_IDLE, SRG_RUN}, the default speed constant (3472) and the 32-bit period typedef `period_t`, shared with the speed controller.
- Single sub-module `period_counter`: loadable down-counter with terminal-count flag and clamp-on-load.
- The top level holds the FSM, the request/ack logic and the miss counter.

## Test plan
- Reset, then `div_count` = 4 and `start` pulse at edge 0 → `sample_req` rises after edges 4, 8, 12 (with ack one cycle after each rise); `overrun` stays 0.
- `div_count` changes from 10 to 6 mid-period (at cycle 3 after a tick) → next tick still 10 cycles after the previous one, then 6-cycle spacing; `active_period` = 6 after that terminal edge.
- `div_count` = 0 and `div_count` = 1 → each tick spaced 2 cycles (`MIN_DIV`); `active_period` = 2.
- `div_count` = 3, never ack → `sample_req` stays 1; `overrun` = 1 after the second tick; `missed` counts 1, 2, … and saturates at 255 after 256 overrun ticks.
- `start` and `stop` together in IDLE → stays IDLE. `stop` on a terminal edge → no request. `reset_n` low for 1 cycle mid-RUN → all outputs return to reset values immediately.
- Tick coinciding with `sample_ack` → `sample_req` remains 1, `missed` unchanged. With `SRG_TOGGLE_OUT_EN`, `tick_toggle` inverts on each of these ticks.
